// File: rtl/rc5_words_to_bytes.sv
`timescale 1ns/1ps
// rc5_words_to_bytes
//   Unpacks c words of w bits, read from a synchronous word RAM, into a
//   little-endian byte stream with valid/ready handshake: byte k is bits
//   [8*(k mod u)+7 : 8*(k mod u)] of word k/u. Inverse of RC5 key packing.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a transfer (only sampled while idle)
//   word_addr         registered RAM read address
//   word_data         RAM read data for word_addr, valid the cycle after it changes
//   byte_o            current byte (low byte of the shift register)
//   byte_valid        byte_o is valid
//   byte_ready        downstream accepts byte_o
//   byte_index        index k of the byte on byte_o
//   busy              high in every state except idle
//   done              one-cycle pulse after the last byte is accepted
//   checksum          (only with RC5_W2B_CHECKSUM_EN) XOR of all accepted bytes
//
// Optional feature macro: RC5_W2B_CHECKSUM_EN
module rc5_words_to_bytes #(
  parameter int b        = 16,
  parameter int b_length = 4,
  parameter int w        = 32,
  parameter int u        = 4,
  parameter int c        = 4,
  parameter int c_length = 2
) (
`ifdef RC5_W2B_CHECKSUM_EN
  output logic [7:0]          checksum,
`endif
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [c_length-1:0] word_addr,
  input  logic [w-1:0]        word_data,
  output logic [7:0]          byte_o,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic [b_length-1:0] byte_index,
  output logic                busy,
  output logic                done
);

  localparam int PW = (u > 1) ? $clog2(u) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

  state_t        state;
  logic [w-1:0]  shreg;
  logic [PW-1:0] pos;     // byte position within the current word
  logic          hs;

  assign hs     = byte_valid & byte_ready;
  assign byte_o = shreg[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      word_addr  <= '0;
      byte_index <= '0;
      shreg      <= '0;
      pos        <= '0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            word_addr  <= '0;
            byte_index <= '0;
            pos        <= '0;
            busy       <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          shreg      <= word_data;
          byte_valid <= 1'b1;
          state      <= S_SEND;
        end
        S_SEND: begin
          if (hs) begin
            shreg <= shreg >> 8;
            if (byte_index == b_length'(b - 1)) begin
              // Last byte: no further RAM read even if the word is partial.
              byte_valid <= 1'b0;
              done       <= 1'b1;
              state      <= S_DONE;
            end else begin
              byte_index <= byte_index + b_length'(1);
              if (pos == PW'(u - 1)) begin
                // Word exhausted: one bubble cycle to fetch the next word.
                pos        <= '0;
                byte_valid <= 1'b0;
                if (word_addr != c_length'(c - 1))
                  word_addr <= word_addr + c_length'(1);
                state      <= S_FETCH;
              end else begin
                pos <= pos + PW'(1);
              end
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RC5_W2B_CHECKSUM_EN
  // Cleared on the start-sampling edge, then folds in every accepted byte;
  // holds from the done cycle until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      checksum <= '0;
    else if (state == S_IDLE && start)
      checksum <= '0;
    else if (state == S_SEND && hs)
      checksum <= checksum ^ shreg[7:0];
  end
`endif

endmodule
